// File: rtl/branch_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch stall/flush controller.
//   state_e    : controller FSM state encoding
//   ctrl_t     : bundle of pipeline control outputs
//   NEED_*     : stall lengths for each hazard class
//   reg_match  : true when a non-zero destination feeds a given source
package branch_stall_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned STALL_CNT_W = 2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pc_src;
  } ctrl_t;

  localparam logic [STALL_CNT_W-1:0] NEED_H2  = 2'd2;
  localparam logic [STALL_CNT_W-1:0] NEED_H1  = 2'd1;
  localparam logic [REG_W-1:0]       REG_ZERO = 5'd0;

  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // $zero never carries a dependency
  function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
    return (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/branch_stall_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
//   clk, reset : clock, synchronous active-high clear
//   inc        : count this cycle
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_stall_ctrl.sv
// Stall/flush controller for ID-stage branch resolution. Stalls when load
// data cannot be forwarded in time, flushes IF/ID on a taken branch, and
// counts stall cycles and flushes.
//   clk, reset          : clock, synchronous active-high reset
//   ext_stall           : memory freeze, holds everything
//   IF_ID_* / ID_EX_* / EX_MEM_* : instruction fields of ID, EX, MEM stages
//   branch_taken        : ID comparator result
//   PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, PC_Src : control (combinational)
//   stall_count, flush_count : saturating event counters
module branch_stall_ctrl
  import branch_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_stall,
  input  logic             IF_ID_Branch,
  input  logic             IF_ID_UsesRs,
  input  logic             IF_ID_UsesRt,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             EX_MEM_MemRead,
  input  logic [REG_W-1:0] EX_MEM_rd,
  input  logic             branch_taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             PC_Src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STALL_CNT_W-1:0] need;
  ctrl_t                  ctrl;

  // Hazard classification; ALU producers are covered by forwarding
  always_comb begin
    need = '0;
    if (IF_ID_Branch) begin
      if (ID_EX_MemRead &&
          (reg_match(ID_EX_rd, IF_ID_rs) || reg_match(ID_EX_rd, IF_ID_rt))) begin
        need = NEED_H2;
      end else if (EX_MEM_MemRead &&
          (reg_match(EX_MEM_rd, IF_ID_rs) || reg_match(EX_MEM_rd, IF_ID_rt))) begin
        need = NEED_H1;
      end
    end else if (ID_EX_MemRead &&
        ((IF_ID_UsesRs && reg_match(ID_EX_rd, IF_ID_rs)) ||
         (IF_ID_UsesRt && reg_match(ID_EX_rd, IF_ID_rt)))) begin
      need = NEED_H1;
    end
  end

  // Next state and control outputs: reset > freeze > stall > flush > run
  always_comb begin
    ctrl        = CTRL_RUN;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      ctrl        = CTRL_RUN;
      state_d     = RUN;
      stall_cnt_d = '0;
    end else if (ext_stall) begin
      ctrl = CTRL_FREEZE;
    end else if (state_q == STALL) begin
      ctrl        = CTRL_STALL;
      stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
      if (stall_cnt_q == STALL_CNT_W'(1)) begin
        state_d = RUN;
      end
    end else if (need != '0) begin
      // A one-cycle stall resolves on re-evaluation, so it never leaves RUN
      ctrl        = CTRL_STALL;
      stall_cnt_d = need - STALL_CNT_W'(1);
      state_d     = (need == NEED_H1) ? RUN : STALL;
    end else if (IF_ID_Branch && branch_taken) begin
      ctrl = CTRL_FLUSH;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PC_Write     = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign ID_EX_Bubble = ctrl.id_ex_bubble;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign PC_Src       = ctrl.pc_src;

  // Bubble and flush are already masked during freeze and reset
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.id_ex_bubble),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.if_id_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Self-checking bench for branch_stall_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_branch_stall_ctrl;

  localparam logic [4:0] RUNV    = 5'b11000;
  localparam logic [4:0] STALLV  = 5'b00100;
  localparam logic [4:0] FLUSHV  = 5'b11011;
  localparam logic [4:0] FREEZEV = 5'b00000;

  logic clk = 1'b0;
  logic reset, ext_stall, IF_ID_Branch, IF_ID_UsesRs, IF_ID_UsesRt;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rd, EX_MEM_rd;
  logic ID_EX_MemRead, EX_MEM_MemRead, branch_taken;
  logic PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, PC_Src;
  logic [15:0] stall_count, flush_count;
  logic [4:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: remaining stall cycles and counter values
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  branch_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .IF_ID_Branch(IF_ID_Branch), .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
    .branch_taken(branch_taken),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .PC_Src(PC_Src),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign obs = {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, PC_Src};

  // ---------------- behavioural model ----------------
  function automatic int hazard_need();
    bit ex_hit, mem_hit;
    if (IF_ID_Branch) begin
      ex_hit  = (ID_EX_rd != 0) && (ID_EX_rd == IF_ID_rs || ID_EX_rd == IF_ID_rt);
      mem_hit = (EX_MEM_rd != 0) && (EX_MEM_rd == IF_ID_rs || EX_MEM_rd == IF_ID_rt);
      if (ID_EX_MemRead && ex_hit) return 2;
      if (EX_MEM_MemRead && mem_hit) return 1;
      return 0;
    end
    ex_hit = (ID_EX_rd != 0) &&
             ((IF_ID_UsesRs && ID_EX_rd == IF_ID_rs) || (IF_ID_UsesRt && ID_EX_rd == IF_ID_rt));
    return (ID_EX_MemRead && ex_hit) ? 1 : 0;
  endfunction

  function automatic logic [4:0] model_ctrl();
    if (reset) return RUNV;
    if (ext_stall) return FREEZEV;
    if (m_left > 0 || hazard_need() > 0) return STALLV;
    if (IF_ID_Branch && branch_taken) return FLUSHV;
    return RUNV;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_update();
    int n;
    if (reset) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else if (!ext_stall) begin
      if (m_left > 0) begin
        m_left--;
        m_stall = sat_inc(m_stall);
      end else begin
        n = hazard_need();
        if (n > 0) begin
          m_left  = n - 1;
          m_stall = sat_inc(m_stall);
        end else if (IF_ID_Branch && branch_taken) begin
          m_flush = sat_inc(m_flush);
        end
      end
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic clear_inputs();
    ext_stall = 0; IF_ID_Branch = 0; IF_ID_UsesRs = 0; IF_ID_UsesRt = 0;
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_MemRead = 0; ID_EX_rd = 0;
    EX_MEM_MemRead = 0; EX_MEM_rd = 0; branch_taken = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    advance();
    advance();
    reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    advance();
    settle();
    n_checks++;
    if (obs !== RUNV) begin n_fail++; $display("FAIL reset_ctrl got %b want %b", obs, RUNV); end
    n_checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_count, flush_count);
    end
    advance();
    reset = 0;
  endtask

  // lw $s0 in EX, beq $s0,$s1 in ID
  task automatic test_h2();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 16; IF_ID_rt = 17; branch_taken = 1;
    ID_EX_MemRead = 1; ID_EX_rd = 16;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL h2_c0 got %b want %b", obs, STALLV); end
    advance();
    ID_EX_MemRead = 0; ID_EX_rd = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 16;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL h2_c1 got %b want %b", obs, STALLV); end
    advance();
    EX_MEM_MemRead = 0; EX_MEM_rd = 0; branch_taken = 0;
    settle(); n_checks++;
    if (obs !== RUNV) begin n_fail++; $display("FAIL h2_c2 got %b want %b", obs, RUNV); end
    n_checks++;
    if (stall_count !== 16'd2) begin n_fail++; $display("FAIL h2_stall_count got %0d want 2", stall_count); end
    advance();
  endtask

  // lw $s0 in MEM, beq $s1,$s0 in ID, branch then taken
  task automatic test_h1b_then_flush();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 17; IF_ID_rt = 16; branch_taken = 1;
    EX_MEM_MemRead = 1; EX_MEM_rd = 16;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL h1b_c0 got %b want %b", obs, STALLV); end
    advance();
    EX_MEM_MemRead = 0; EX_MEM_rd = 0;
    settle(); n_checks++;
    if (obs !== FLUSHV) begin n_fail++; $display("FAIL h1b_flush got %b want %b", obs, FLUSHV); end
    n_checks++;
    if (stall_count !== 16'd1) begin n_fail++; $display("FAIL h1b_stall_count got %0d want 1", stall_count); end
    advance();
    IF_ID_Branch = 0; branch_taken = 0;
    settle(); n_checks++;
    if (obs !== RUNV || flush_count !== 16'd1) begin
      n_fail++; $display("FAIL h1b_after got %b/%0d want %b/1", obs, flush_count, RUNV);
    end
    advance();
  endtask

  // addi $s0 in EX, beq $s0 in ID, taken: forwarded, no stall
  task automatic test_alu_forward();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 16; IF_ID_rt = 17; branch_taken = 1;
    ID_EX_MemRead = 0; ID_EX_rd = 16;
    settle(); n_checks++;
    if (obs !== FLUSHV) begin n_fail++; $display("FAIL alu_fwd got %b want %b", obs, FLUSHV); end
    advance();
    clear_inputs();
    settle(); n_checks++;
    if (flush_count !== 16'd1 || stall_count !== 16'd0) begin
      n_fail++; $display("FAIL alu_fwd_counts got %0d/%0d want 0/1", stall_count, flush_count);
    end
    advance();
  endtask

  // $zero never stalls; rt-only use stalls only when UsesRt
  task automatic test_zero_and_h1a();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_MemRead = 1; ID_EX_rd = 0;
    settle(); n_checks++;
    if (obs !== RUNV) begin n_fail++; $display("FAIL zero_reg got %b want %b", obs, RUNV); end
    advance();
    IF_ID_Branch = 0; IF_ID_UsesRs = 1; IF_ID_UsesRt = 0; IF_ID_rs = 9; IF_ID_rt = 8;
    ID_EX_rd = 8;
    settle(); n_checks++;
    if (obs !== RUNV) begin n_fail++; $display("FAIL h1a_unused_rt got %b want %b", obs, RUNV); end
    advance();
    IF_ID_UsesRt = 1;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL h1a_c0 got %b want %b", obs, STALLV); end
    advance();
    ID_EX_MemRead = 0; ID_EX_rd = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 8;
    settle(); n_checks++;
    if (obs !== RUNV || stall_count !== 16'd1) begin
      n_fail++; $display("FAIL h1a_c1 got %b/%0d want %b/1", obs, stall_count, RUNV);
    end
    advance();
  endtask

  // freeze during the second H2 bubble
  task automatic test_ext_stall();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 16; IF_ID_rt = 17; ID_EX_MemRead = 1; ID_EX_rd = 16;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL ext_c0 got %b want %b", obs, STALLV); end
    advance();
    ID_EX_MemRead = 0; ID_EX_rd = 0; EX_MEM_MemRead = 1; EX_MEM_rd = 16;
    ext_stall = 1; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); n_checks++;
      if (obs !== FREEZEV || stall_count !== 16'd1) begin
        n_fail++; $display("FAIL ext_freeze%0d got %b/%0d want %b/1", i, obs, stall_count, FREEZEV);
      end
      advance();
    end
    ext_stall = 0;
    settle(); n_checks++;
    if (obs !== STALLV || stall_count !== 16'd1) begin
      n_fail++; $display("FAIL ext_resume got %b/%0d want %b/1", obs, stall_count, STALLV);
    end
    advance();
    EX_MEM_MemRead = 0; EX_MEM_rd = 0; branch_taken = 0;
    settle(); n_checks++;
    if (obs !== RUNV || stall_count !== 16'd2) begin
      n_fail++; $display("FAIL ext_end got %b/%0d want %b/2", obs, stall_count, RUNV);
    end
    advance();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    IF_ID_Branch = 1; IF_ID_rs = 16; ID_EX_MemRead = 1; ID_EX_rd = 16;
    settle(); n_checks++;
    if (obs !== STALLV) begin n_fail++; $display("FAIL rstmid_c0 got %b want %b", obs, STALLV); end
    advance();
    reset = 1;
    settle(); n_checks++;
    if (obs !== RUNV) begin n_fail++; $display("FAIL rstmid_during got %b want %b", obs, RUNV); end
    advance();
    reset = 0;
    clear_inputs();
    settle(); n_checks++;
    if (obs !== RUNV || stall_count !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_after got %b/%0d/%0d want %b/0/0", obs, stall_count, flush_count, RUNV);
    end
    advance();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      ext_stall      = ($urandom_range(0, 7) == 0);
      IF_ID_Branch   = 1'($urandom_range(0, 1));
      IF_ID_UsesRs   = 1'($urandom_range(0, 1));
      IF_ID_UsesRt   = 1'($urandom_range(0, 1));
      IF_ID_rs       = 5'($urandom_range(0, 3));
      IF_ID_rt       = 5'($urandom_range(0, 3));
      ID_EX_MemRead  = 1'($urandom_range(0, 1));
      ID_EX_rd       = 5'($urandom_range(0, 3));
      EX_MEM_MemRead = 1'($urandom_range(0, 1));
      EX_MEM_rd      = 5'($urandom_range(0, 3));
      branch_taken   = 1'($urandom_range(0, 1));
      settle(); n_checks++;
      if (obs !== model_ctrl() || stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
        n_fail++;
        $display("FAIL rand%0d got %b/%0d/%0d want %b/%0d/%0d", i, obs, stall_count, flush_count,
                 model_ctrl(), m_stall, m_flush);
      end
      advance();
    end
    reset = 0;
  endtask

  // continuous load-use hazard drives stall_count to saturation
  task automatic test_saturation();
    apply_reset();
    IF_ID_UsesRs = 1; IF_ID_rs = 8; ID_EX_MemRead = 1; ID_EX_rd = 8;
    for (int i = 0; i < 65534; i++) advance();
    settle(); n_checks++;
    if (stall_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h want fffe", stall_count); end
    advance();
    settle(); n_checks++;
    if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit got %h want ffff", stall_count); end
    for (int i = 0; i < 5; i++) advance();
    settle(); n_checks++;
    if (stall_count !== 16'hFFFF || obs !== STALLV || flush_count !== 16'd0) begin
      n_fail++; $display("FAIL sat_hold got %h/%b/%0d want ffff/%b/0", stall_count, obs, flush_count, STALLV);
    end
    advance();
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    #1;
    test_reset();
    test_h2();
    test_h1b_then_flush();
    test_alu_forward();
    test_zero_and_h1a();
    test_ext_stall();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_stall_ctrl.md
Name: branch_stall_ctrl

Overview:
- Stall/flush controller paired with the ID-stage branch forwarding unit.
- The forwarding unit supplies operands to the ID-stage comparator from ID/EX and EX/MEM. This block handles the cases forwarding cannot resolve: load data not yet available, and killing the wrong-path fetch on a taken branch.
- Sits beside the hazard logic in ID. Drives PC/IF_ID write enables, the ID/EX bubble and the IF_ID flush.
- Keeps saturating stall and flush event counters.

Parameters:
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- ext_stall  input  1  memory-system freeze; holds all pipeline state
- IF_ID_Branch  input  1  instruction in ID is beq/bne
- IF_ID_UsesRs  input  1  non-branch instruction in ID reads rs
- IF_ID_UsesRt  input  1  non-branch instruction in ID reads rt
- IF_ID_rs  input  5  ID source register 1
- IF_ID_rt  input  5  ID source register 2
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_rd  input  5  destination register of EX instruction
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_rd  input  5  destination register of MEM instruction
- branch_taken  input  1  ID comparator result (uses forwarded operands)
- PC_Write  output  1  PC write enable
- IF_ID_Write  output  1  IF/ID register write enable
- ID_EX_Bubble  output  1  zero the control bits entering ID/EX
- IF_ID_Flush  output  1  clear IF/ID (kill the wrong-path fetch)
- PC_Src  output  1  select branch target
- stall_count  output  CNT_W  cycles spent in STALL
- flush_count  output  CNT_W  taken-branch flushes

Behaviour:
- A register match requires rd != 0 and rd equal to the source.
  - Branch sources: rs and rt.
  - Non-branch sources: rs if UsesRs, rt if UsesRt.
- Hazard classification, evaluated in RUN only. Priority is top to bottom.
  - H2: branch, and ID_EX_MemRead with an ID_EX_rd match. Stall 2 cycles.
  - H1b: branch, and EX_MEM_MemRead with an EX_MEM_rd match. Stall 1 cycle.
  - H1a: non-branch, and ID_EX_MemRead with an ID_EX_rd match. Stall 1 cycle.
  - A branch that matches an ALU instruction (RegWrite, not MemRead) in EX or MEM is not a hazard; forwarding covers it.
- FSM states: RUN, STALL. Register stall_cnt is 2 bits.
  - RUN with a hazard: this cycle outputs PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. stall_cnt <= (need-1) and the state moves to STALL, unless need is 1, in which case the state stays RUN. Re-evaluation next cycle then finds no hazard.
  - STALL: outputs the same stall pattern. stall_cnt decrements. The state returns to RUN when stall_cnt is 1 at the clock edge. With need=2 this gives 2 bubble cycles total.
  - RUN, no hazard, branch with branch_taken=1: PC_Src=1, IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1. This is one cycle, combinational.
  - RUN, no hazard, otherwise: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
- Stall beats flush: branch_taken is ignored while a hazard is detected or the state is STALL.
- ext_stall=1 beats everything.
  - Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0, PC_Src=0.
  - State, stall_cnt and the counters hold.
  - Hazard detection does not advance.
- Counters: stall_count +1 per non-frozen cycle with ID_EX_Bubble=1. flush_count +1 per cycle with IF_ID_Flush=1. Both saturate at all-ones, with no wrap.
- While reset=1:
  - Outputs are PC_Write=1, IF_ID_Write=1, others 0.
  - Next state is RUN, with stall_cnt=0 and counters=0.
  - A reset mid-STALL abandons the stall.
- Latency: zero-cycle combinational control from the ID inputs. The only registered elements are state, stall_cnt and the counters.

Decomposition:
- Shared package holds:
  - state encoding: RUN=1'b0, STALL=1'b1
  - stall-need constants: NEED_H2=2, NEED_H1=1
  - REG_ZERO=5'd0
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiate it twice.

Test Plan:
- lw $s0 in EX, beq $s0,$s1 in ID -> 2 cycles of PC_Write=0/ID_EX_Bubble=1, then RUN; stall_count=2.
- lw $s0 in MEM, beq $s1,$s0 in ID -> 1 bubble cycle; stall_count=1; then a taken branch gives IF_ID_Flush=1 and PC_Src=1 for one cycle; flush_count=1.
- addi $s0 in EX, beq $s0 in ID, branch_taken=1 -> no stall; IF_ID_Flush=1 the same cycle.
- lw $zero in EX, beq $zero in ID -> no stall; lw $t0 then add using rt=$t0 -> 1 bubble.
- ext_stall=1 for 3 cycles during the second STALL cycle of H2 -> all enables 0, bubble 0, stall_count frozen at 1; resumes and ends at 2.
- reset asserted during STALL -> next cycle RUN, counters 0, PC_Write=1. Separately, preload stall_count to 0xFFFF via repeated stalls -> it holds at 0xFFFF.
